// File: rtl/approx_eval_pkg.sv
// Shared widths and FSM state type for the approximate-multiplier error evaluator.
package approx_eval_pkg;
    localparam int OP_W     = 8;
    localparam int PROD_W   = 16;
    localparam int PAIR_CNT = 65536;
    localparam int CNT_W    = 16;
    localparam int ERR_W    = 17;
    localparam int SUM_W    = 32;
    localparam int BIAS_W   = 33;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
endpackage

// File: rtl/ed_calc.sv
// Absolute and signed difference of two unsigned products (x = approximate, y = exact).
module ed_calc
    import approx_eval_pkg::*;
(
    input  logic [PROD_W-1:0] x,
    input  logic [PROD_W-1:0] y,
    output logic [PROD_W-1:0] abs_diff,
    output logic [PROD_W:0]   sdiff
);
    // Zero-extend both sides so the 17-bit result is the two's complement x - y.
    assign sdiff    = {1'b0, x} - {1'b0, y};
    assign abs_diff = (x >= y) ? (x - y) : (y - x);
endmodule

// File: rtl/approx_mul_err_eval.sv
// Exhaustive 8x8 sweep of an external approximate multiplier, accumulating error statistics.
// Optional signed bias accumulator enabled by defining APPROX_EVAL_BIAS_EN.
module approx_mul_err_eval
    import approx_eval_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [OP_W-1:0]     a,
    output logic [OP_W-1:0]     b,
    input  logic [PROD_W-1:0]   prod8,
    output logic                busy,
    output logic                done,
    output logic [ERR_W-1:0]    err_cnt,
    output logic [PROD_W-1:0]   max_ed,
`ifdef APPROX_EVAL_BIAS_EN
    output logic [SUM_W-1:0]    sum_ed,
    output logic signed [BIAS_W-1:0] bias_sum
`else
    output logic [SUM_W-1:0]    sum_ed
`endif
);
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                clr;

    logic                v1_q, v1_d;
    logic                last1_q, last1_d;
    logic [PROD_W-1:0]   approx1_q, approx1_d;
    logic [PROD_W-1:0]   exact1_q, exact1_d;

    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
    logic [PROD_W-1:0]   max_ed_q, max_ed_d;
    logic [SUM_W-1:0]    sum_ed_q, sum_ed_d;

    logic [PROD_W-1:0]   ed;
    logic [PROD_W:0]     sdiff;

    logic                sweeping;

    assign sweeping = (state_q == SWEEP);
    assign a        = sweeping ? cnt_q[CNT_W-1:OP_W] : '0;
    assign b        = sweeping ? cnt_q[OP_W-1:0]     : '0;
    assign busy     = (state_q == SWEEP) || (state_q == DRAIN);
    assign done     = done_q;
    assign err_cnt  = err_cnt_q;
    assign max_ed   = max_ed_q;
    assign sum_ed   = sum_ed_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = SWEEP;
                cnt_d   = '0;
                clr     = 1'b1;
            end
            SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {CNT_W{1'b1}}) state_d = DRAIN;
            end
            // Stage 2 absorbs the final pair on this edge, so results are final with done.
            DRAIN: if (v1_q && last1_q) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        v1_d      = sweeping;
        last1_d   = sweeping && (cnt_q == {CNT_W{1'b1}});
        approx1_d = prod8;
        exact1_d  = PROD_W'(a) * PROD_W'(b);
    end

    ed_calc u_ed (
        .x        (approx1_q),
        .y        (exact1_q),
        .abs_diff (ed),
        .sdiff    (sdiff)
    );

    always_comb begin
        err_cnt_d = err_cnt_q;
        max_ed_d  = max_ed_q;
        sum_ed_d  = sum_ed_q;
        if (clr) begin
            err_cnt_d = '0;
            max_ed_d  = '0;
            sum_ed_d  = '0;
        end else if (v1_q) begin
            err_cnt_d = err_cnt_q + ERR_W'(sdiff != '0);
            max_ed_d  = (ed > max_ed_q) ? ed : max_ed_q;
            sum_ed_d  = sum_ed_q + SUM_W'(ed);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            v1_q      <= 1'b0;
            last1_q   <= 1'b0;
            approx1_q <= '0;
            exact1_q  <= '0;
            err_cnt_q <= '0;
            max_ed_q  <= '0;
            sum_ed_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            v1_q      <= v1_d;
            last1_q   <= last1_d;
            approx1_q <= approx1_d;
            exact1_q  <= exact1_d;
            err_cnt_q <= err_cnt_d;
            max_ed_q  <= max_ed_d;
            sum_ed_q  <= sum_ed_d;
        end
    end

`ifdef APPROX_EVAL_BIAS_EN
    logic [BIAS_W-1:0] bias_sum_q, bias_sum_d;

    always_comb begin
        bias_sum_d = bias_sum_q;
        if (clr)
            bias_sum_d = '0;
        else if (v1_q)
            bias_sum_d = bias_sum_q + {{(BIAS_W-PROD_W-1){sdiff[PROD_W]}}, sdiff};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bias_sum_q <= '0;
        else     bias_sum_q <= bias_sum_d;
    end

    assign bias_sum = $signed(bias_sum_q);
`endif
endmodule

// File: tb/tb_approx_mul_err_eval.sv
// Directed sequence with a randomized approximate-multiplier model and a software golden sweep.
module tb_approx_mul_err_eval;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a, b;
    logic [15:0] prod8;
    logic        busy, done;
    logic [16:0] err_cnt;
    logic [15:0] max_ed;
    logic [31:0] sum_ed;
`ifdef APPROX_EVAL_BIAS_EN
    logic signed [32:0] bias_sum;
`endif

    int checks = 0;
    int failures = 0;
    int tab[256];

    approx_mul_err_eval dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .prod8   (prod8),
        .busy    (busy),
        .done    (done),
        .err_cnt (err_cnt),
        .max_ed  (max_ed),
`ifdef APPROX_EVAL_BIAS_EN
        .sum_ed  (sum_ed),
        .bias_sum(bias_sum)
`else
        .sum_ed  (sum_ed)
`endif
    );

    always #5 clk = ~clk;

    // Multiplier under test: exact except for random per-b offsets on a subset of pairs,
    // and a worst-case zero at 255*255.
    function automatic int approx_f(int x, int y);
        int p;
        p = x * y;
        if (x == 255 && y == 255) return 0;
        if ((x + y) % 5 == 0) p = p + tab[y];
        if (p < 0) p = 0;
        if (p > 65535) p = 65535;
        return p;
    endfunction

    always_comb prod8 = 16'(approx_f(int'(a), int'(b)));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        longint g_err, g_max, g_sum, g_bias;
        int n, d, dones;

        for (int i = 0; i < 256; i++) begin
            tab[i] = int'($urandom_range(80, 0)) - 40;
            if ($urandom_range(3, 0) == 0) tab[i] = 0;
        end
        g_err = 0; g_max = 0; g_sum = 0; g_bias = 0;
        for (int x = 0; x < 256; x++)
            for (int y = 0; y < 256; y++) begin
                d = approx_f(x, y) - x * y;
                if (d != 0) g_err++;
                if (d < 0) d = -d;
                if (d > g_max) g_max = d;
                g_sum += d;
                g_bias += approx_f(x, y) - x * y;
            end

        // Reset state
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_max", max_ed, 0);
        chk("rst_sum", sum_ed, 0);
`ifdef APPROX_EVAL_BIAS_EN
        chk("rst_bias", bias_sum, 0);
`endif
        rst = 1'b0;
        tick();

        // Abort a sweep with reset at cycle 1000
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 1000; i++) tick();
        chk("abort_busy_pre", busy, 1);
        chk("abort_a_pre", a, 1000 >> 8);
        chk("abort_b_pre", b, 1000 & 255);
        rst = 1'b1; #1;
        chk("abort_busy", busy, 0);
        chk("abort_err", err_cnt, 0);
        chk("abort_max", max_ed, 0);
        chk("abort_sum", sum_ed, 0);
        chk("abort_a", a, 0);
        tick();
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);
        chk("abort_idle_busy", busy, 0);

        // Full sweep with an ignored start re-pulse at cycle 500
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 70000) begin
            start = (n == 500);
            tick();
            n++;
            if (n == 1)     chk("sweep_busy", busy, 1);
            if (n == 300)   begin chk("pair300_a", a, 300 >> 8); chk("pair300_b", b, 300 & 255); end
            if (n == 40000) begin chk("pair40000_a", a, 40000 >> 8); chk("pair40000_b", b, 40000 & 255); end
            if (n == 65535) begin chk("last_a", a, 255); chk("last_b", b, 255); end
            if (n == 65536) begin chk("drain_a", a, 0); chk("drain_busy", busy, 1); end
        end
        start = 1'b0;
        chk("done_latency", n, 65537);
        chk("err_cnt", err_cnt, g_err);
        chk("max_ed", max_ed, g_max);
        chk("sum_ed", sum_ed, g_sum);
`ifdef APPROX_EVAL_BIAS_EN
        chk("bias_sum", bias_sum, g_bias);
`endif
        tick();
        chk("done_pulse_len", done, 0);
        chk("post_busy", busy, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("hold_err", err_cnt, g_err);
        chk("hold_max", max_ed, g_max);
        chk("hold_sum", sum_ed, g_sum);
        chk("idle_a", a, 0);
        chk("idle_b", b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
